branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters. It sits directly upstream of the instruction fetch stage.
- Each cycle it looks up the fetch stage's next PC and returns a predicted-taken flag plus target address, which fetch uses combinationally to select the next PC.
- The execute stage writes resolved branch outcomes back through a single update port.
- Saturating performance counters track lookups and mispredicts.

---
 rtl/branch_predictor.sv | 104 ++++++++++
 tb/tb_branch_predictor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup for fetch, one registered update port from execute, and
// saturating lookup/mispredict counters.
module branch_predictor #(
  parameter int INDEX_BITS = 3,
  parameter int PC_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pc_lookup,
  output logic [PC_WIDTH-1:0] target_bp,
  output logic                target_en_bp,
  input  logic                update_en,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target,
  input  logic                update_mispredict,
  output logic [15:0]         lookup_cnt,
  output logic [15:0]         mispredict_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS;

  // Handshake: the update port has no ready; update_en is the valid and an
  // update is accepted on every non-reset posedge where it is high.

  logic [ENTRIES-1:0]               valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [ENTRIES-1:0][PC_WIDTH-1:0] target_q, target_d;
  logic [ENTRIES-1:0][1:0]          ctr_q, ctr_d;
  logic [15:0]                      lookup_cnt_q, lookup_cnt_d;
  logic [15:0]                      mispredict_cnt_q, mispredict_cnt_d;

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;

  // Lookup reads the pre-update array; no bypass from a same-cycle update.
  assign lk_idx       = pc_lookup[INDEX_BITS-1:0];
  assign lk_tag       = pc_lookup[PC_WIDTH-1:INDEX_BITS];
  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign target_en_bp = !reset && lk_hit && ctr_q[lk_idx][1];
  assign target_bp    = target_en_bp ? target_q[lk_idx] : '0;

  assign up_idx = update_pc[INDEX_BITS-1:0];
  assign up_tag = update_pc[PC_WIDTH-1:INDEX_BITS];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d          = valid_q;
    tag_d            = tag_q;
    target_d         = target_q;
    ctr_d            = ctr_q;
    lookup_cnt_d     = lookup_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i]  = 1'b0;
        tag_d[i]    = '0;
        target_d[i] = '0;
        ctr_d[i]    = 2'b01;
      end
      lookup_cnt_d     = '0;
      mispredict_cnt_d = '0;
    end else begin
      if (lookup_cnt_q != 16'hFFFF) lookup_cnt_d = lookup_cnt_q + 16'd1;
      if (update_en && update_mispredict && (mispredict_cnt_q != 16'hFFFF))
        mispredict_cnt_d = mispredict_cnt_q + 16'd1;
      if (update_en) begin
        if (up_hit) begin
          if (update_taken) begin
            if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
            target_d[up_idx] = update_target;
          end else if (ctr_q[up_idx] != 2'b00) begin
            ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
          end
        end else if (update_taken) begin
          // Allocation overwrites whatever alias occupied the slot.
          valid_d[up_idx]  = 1'b1;
          tag_d[up_idx]    = up_tag;
          target_d[up_idx] = update_target;
          ctr_d[up_idx]    = 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    valid_q          <= valid_d;
    tag_q            <= tag_d;
    target_q         <= target_d;
    ctr_q            <= ctr_d;
    lookup_cnt_q     <= lookup_cnt_d;
    mispredict_cnt_q <= mispredict_cnt_d;
  end

  assign lookup_cnt     = lookup_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: table-driven scenarios with an expected-value
// queue covering prediction outputs and both performance counters.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [15:0] pc_lookup;
  logic [15:0] target_bp;
  logic        target_en_bp;
  logic        update_en;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic        update_mispredict;
  logic [15:0] lookup_cnt;
  logic [15:0] mispredict_cnt;

  branch_predictor #(.INDEX_BITS(3), .PC_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_lookup         (pc_lookup),
    .target_bp         (target_bp),
    .target_en_bp      (target_en_bp),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .lookup_cnt        (lookup_cnt),
    .mispredict_cnt    (mispredict_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [15:0] pc;
    logic        ue;
    logic [15:0] upc;
    logic        ut;
    logic [15:0] utgt;
    logic        um;
    logic        exp_en;
    logic [15:0] exp_tgt;
  } row_t;

  // scoreboard: {en, target, lookup_cnt, mispredict_cnt}
  logic [48:0] exp_q[$];
  logic [48:0] exp_v;
  logic [48:0] got_v;
  int          checks;
  int          fails;
  logic [15:0] model_lk;
  logic [15:0] model_mis;

  function automatic row_t mk(input logic rst, input logic [15:0] pc, input logic ue,
                              input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                              input logic um, input logic en, input logic [15:0] tgt);
    row_t r;
    r.rst = rst; r.pc = pc; r.ue = ue; r.upc = upc; r.ut = ut;
    r.utgt = utgt; r.um = um; r.exp_en = en; r.exp_tgt = tgt;
    return r;
  endfunction

  function automatic row_t look(input logic [15:0] pc, input logic en, input logic [15:0] tgt);
    return mk(1'b0, pc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, en, tgt);
  endfunction

  function automatic row_t upd(input logic [15:0] pc, input logic [15:0] upc, input logic ut,
                               input logic [15:0] utgt, input logic um,
                               input logic en, input logic [15:0] tgt);
    return mk(1'b0, pc, 1'b1, upc, ut, utgt, um, en, tgt);
  endfunction

  // driver: apply one row at the falling edge and record what it must produce
  task automatic drive_row(input row_t r);
    @(negedge clk);
    reset             = r.rst;
    pc_lookup         = r.pc;
    update_en         = r.ue;
    update_pc         = r.upc;
    update_taken      = r.ut;
    update_target     = r.utgt;
    update_mispredict = r.um;
    exp_q.push_back({r.exp_en, r.exp_tgt, model_lk, model_mis});
    if (r.rst) begin
      model_lk  = 16'h0;
      model_mis = 16'h0;
    end else begin
      if (model_lk != 16'hFFFF) model_lk = model_lk + 16'd1;
      if (r.ue && r.um && model_mis != 16'hFFFF) model_mis = model_mis + 16'd1;
    end
  endtask

  task automatic test_reset();
    row_t rows[$];
    reset = 1'b1; pc_lookup = 16'h0005; update_en = 1'b0; update_pc = 16'h0;
    update_taken = 1'b0; update_target = 16'h0; update_mispredict = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (target_en_bp !== 1'b0 || target_bp !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%0b tgt=%h, expected en=0 tgt=0000", target_en_bp, target_bp);
    end
    checks++;
    if (lookup_cnt !== 16'h0 || mispredict_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_counters: got lk=%0d mis=%0d, expected 0 and 0", lookup_cnt, mispredict_cnt);
    end
    model_lk = 16'h0; model_mis = 16'h0;
    rows.push_back(look(16'h0005, 1'b0, 16'h0));
    rows.push_back(look(16'h0005, 1'b0, 16'h0));
    rows.push_back(mk(1'b0, 16'h0005, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #1; exp_v = exp_q.pop_front(); got_v = {target_en_bp, target_bp, lookup_cnt, mispredict_cnt};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL reset row %0d: got en=%0b tgt=%h lk=%0d mis=%0d, expected en=%0b tgt=%h lk=%0d mis=%0d",
                 i, got_v[48], got_v[47:32], got_v[31:16], got_v[15:0], exp_v[48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
      end
    end
  endtask

  task automatic test_allocate();
    row_t rows[$];
    rows.push_back(upd(16'h0005, 16'h0005, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0));
    rows.push_back(look(16'h0005, 1'b1, 16'h0010));
    rows.push_back(look(16'h000D, 1'b0, 16'h0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #1; exp_v = exp_q.pop_front(); got_v = {target_en_bp, target_bp, lookup_cnt, mispredict_cnt};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL allocate row %0d: got en=%0b tgt=%h lk=%0d mis=%0d, expected en=%0b tgt=%h lk=%0d mis=%0d",
                 i, got_v[48], got_v[47:32], got_v[31:16], got_v[15:0], exp_v[48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
      end
    end
  endtask

  task automatic test_counter_sat();
    row_t rows[$];
    rows.push_back(upd(16'h0005, 16'h0005, 1'b0, 16'hBEEF, 1'b1, 1'b1, 16'h0010)); // 10->01
    rows.push_back(upd(16'h0005, 16'h0005, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0));    // 01->00
    rows.push_back(upd(16'h0005, 16'h0005, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0));    // 00->01
    rows.push_back(upd(16'h0005, 16'h0005, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0));    // 01->10
    rows.push_back(upd(16'h0005, 16'h0005, 1'b1, 16'h0012, 1'b1, 1'b1, 16'h0010)); // 10->11
    rows.push_back(upd(16'h0005, 16'h0005, 1'b1, 16'h0012, 1'b0, 1'b1, 16'h0012));
    rows.push_back(upd(16'h0005, 16'h0005, 1'b1, 16'h0012, 1'b0, 1'b1, 16'h0012));
    rows.push_back(upd(16'h0005, 16'h0005, 1'b1, 16'h0012, 1'b0, 1'b1, 16'h0012));
    rows.push_back(upd(16'h0005, 16'h0005, 1'b0, 16'hBEEF, 1'b0, 1'b1, 16'h0012)); // 11->10
    rows.push_back(upd(16'h0005, 16'h0005, 1'b0, 16'hBEEF, 1'b0, 1'b1, 16'h0012)); // 10->01
    rows.push_back(look(16'h0005, 1'b0, 16'h0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #1; exp_v = exp_q.pop_front(); got_v = {target_en_bp, target_bp, lookup_cnt, mispredict_cnt};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL counter row %0d: got en=%0b tgt=%h lk=%0d mis=%0d, expected en=%0b tgt=%h lk=%0d mis=%0d",
                 i, got_v[48], got_v[47:32], got_v[31:16], got_v[15:0], exp_v[48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
      end
    end
  endtask

  task automatic test_same_cycle();
    row_t rows[$];
    rows.push_back(upd(16'h0003, 16'h0003, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0));
    rows.push_back(look(16'h0003, 1'b1, 16'h0020));
    rows.push_back(upd(16'h0003, 16'h0003, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020));
    rows.push_back(look(16'h0003, 1'b0, 16'h0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #1; exp_v = exp_q.pop_front(); got_v = {target_en_bp, target_bp, lookup_cnt, mispredict_cnt};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL same_cycle row %0d: got en=%0b tgt=%h lk=%0d mis=%0d, expected en=%0b tgt=%h lk=%0d mis=%0d",
                 i, got_v[48], got_v[47:32], got_v[31:16], got_v[15:0], exp_v[48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
      end
    end
  endtask

  task automatic test_alias();
    row_t rows[$];
    rows.push_back(upd(16'h0005, 16'h0005, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0));    // 01->10
    rows.push_back(upd(16'h0005, 16'h000D, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0010)); // replace
    rows.push_back(look(16'h0005, 1'b0, 16'h0));
    rows.push_back(look(16'h000D, 1'b1, 16'h0040));
    rows.push_back(look(16'h0015, 1'b0, 16'h0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #1; exp_v = exp_q.pop_front(); got_v = {target_en_bp, target_bp, lookup_cnt, mispredict_cnt};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL alias row %0d: got en=%0b tgt=%h lk=%0d mis=%0d, expected en=%0b tgt=%h lk=%0d mis=%0d",
                 i, got_v[48], got_v[47:32], got_v[31:16], got_v[15:0], exp_v[48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    rows.push_back(mk(1'b1, 16'h000D, 1'b1, 16'h000D, 1'b1, 16'h0099, 1'b1, 1'b0, 16'h0));
    rows.push_back(look(16'h000D, 1'b0, 16'h0));
    rows.push_back(look(16'h0003, 1'b0, 16'h0));
    rows.push_back(look(16'h0005, 1'b0, 16'h0));
    rows.push_back(upd(16'h000D, 16'h000D, 1'b1, 16'h0044, 1'b0, 1'b0, 16'h0));
    rows.push_back(look(16'h000D, 1'b1, 16'h0044));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #1; exp_v = exp_q.pop_front(); got_v = {target_en_bp, target_bp, lookup_cnt, mispredict_cnt};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL reset_mid row %0d: got en=%0b tgt=%h lk=%0d mis=%0d, expected en=%0b tgt=%h lk=%0d mis=%0d",
                 i, got_v[48], got_v[47:32], got_v[31:16], got_v[15:0], exp_v[48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
      end
    end
  endtask

  task automatic test_lookup_saturate();
    logic [15:0] mis_before;
    @(negedge clk);
    reset = 1'b0; update_en = 1'b0; update_mispredict = 1'b0;
    pc_lookup = 16'($urandom_range(0, 16'hFFFF));
    mis_before = model_mis;
    repeat (65540) @(negedge clk);
    #1;
    checks++;
    if (lookup_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL lookup_saturate: got lk=%h, expected ffff", lookup_cnt);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (lookup_cnt !== 16'hFFFF || mispredict_cnt !== mis_before) begin
      fails++;
      $display("FAIL lookup_hold: got lk=%h mis=%0d, expected lk=ffff mis=%0d", lookup_cnt, mispredict_cnt, mis_before);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    model_lk  = 16'h0;
    model_mis = 16'h0;
    test_reset();
    test_allocate();
    test_counter_sat();
    test_same_cycle();
    test_alias();
    test_reset_mid();
    test_lookup_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
